// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master shift engine.
// Holds the FSM state encoding, the chip-select idle level and the mode encodings.
package spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD
   } spi_state_t;

   localparam logic CS_IDLE = 1'b1;

   // Mode numbers are {cpol, cpha}.
   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   function automatic logic [1:0] spi_mode(input logic cpol, input logic cpha);
      return {cpol, cpha};
   endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer for the SPI shifter: a one-cycle tick every div+1 enabled cycles.
// The count is held at zero whenever the timer is disabled.
module spi_clk_div #(
   parameter int div_w = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [div_w-1:0] div,
   output logic             tick
);

   logic [div_w-1:0] cnt;

   assign tick = en && (cnt == div);

   always_ff @(posedge clk) begin
      if (rst || !en || tick) cnt <= '0;
      else                    cnt <= cnt + div_w'(1);
   end

endmodule

// File: rtl/spi_shifter.sv
// SPI master shift engine: one data_w-bit word per transfer, modes 0-3, one-hot active-low CS.
// Optional MOSI-to-MISO internal loopback is enabled by defining SPI_SHIFTER_LOOPBACK_EN.
//
// state    | meaning
// IDLE     | sck follows live cpol; waits for start
// SETUP    | CS asserted, first bit presented (cpha=0); lasts div+1 cycles
// SHIFT    | 2*data_w SCK edges, one every div+1 cycles
// HOLD     | CS held div+1 cycles, then one done cycle before IDLE
module spi_shifter
   import spi_pkg::*;
#(
   parameter int data_w = 8,
   parameter int cs_w   = 8,
   parameter int div_w  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [data_w-1:0]         tx_data,
   input  logic [div_w-1:0]          div,
   input  logic                      cpol,
   input  logic                      cpha,
   input  logic [$clog2(cs_w)-1:0]   cs_sel,
`ifdef SPI_SHIFTER_LOOPBACK_EN
   input  logic                      loopback,
`endif
   output logic                      busy,
   output logic                      done,
   output logic [data_w-1:0]         rx_data,
   output logic                      spi_mosi,
   input  logic                      spi_miso,
   output logic                      spi_sck,
   output logic [cs_w-1:0]           spi_cs
);

   localparam int EDGE_W = $clog2(2*data_w+1);
   localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2*data_w-1);

   spi_state_t          state;
   logic [data_w-1:0]   tx_sh;
   logic [data_w-1:0]   rx_sh;
   logic [div_w-1:0]    div_q;
   logic [1:0]          mode_q;
   logic [EDGE_W-1:0]   edge_cnt;
   logic [cs_w-1:0]     cs_dec;
   logic                tick;
   logic                leading;
   logic                lead_drive;
   logic                idle_lvl;
   logic                in_bit;

   spi_clk_div #(.div_w(div_w)) u_clk_div (
      .clk  (clk),
      .rst  (rst),
      .en   (busy),
      .div  (div_q),
      .tick (tick)
   );

   assign leading    = ~edge_cnt[0];
   assign lead_drive = (mode_q == SPI_MODE1) || (mode_q == SPI_MODE3);
   assign idle_lvl   = (mode_q == SPI_MODE2) || (mode_q == SPI_MODE3);

`ifdef SPI_SHIFTER_LOOPBACK_EN
   logic lb_q;

   always_ff @(posedge clk) begin
      if (rst)                              lb_q <= 1'b0;
      else if (state == ST_IDLE && start)   lb_q <= loopback;
   end

   assign in_bit = lb_q ? spi_mosi : spi_miso;
`else
   assign in_bit = spi_miso;
`endif

   // An out-of-range cs_sel matches no line, so every CS stays idle.
   always_comb begin
      cs_dec = {cs_w{CS_IDLE}};
      for (int i = 0; i < cs_w; i++) begin
         if (int'(cs_sel) == i) cs_dec[i] = ~CS_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         rx_data  <= '0;
         spi_mosi <= 1'b0;
         spi_sck  <= 1'b0;
         spi_cs   <= {cs_w{CS_IDLE}};
         tx_sh    <= '0;
         rx_sh    <= '0;
         div_q    <= '0;
         mode_q   <= SPI_MODE0;
         edge_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               spi_sck <= cpol;
               if (start) begin
                  state    <= ST_SETUP;
                  busy     <= 1'b1;
                  div_q    <= div;
                  mode_q   <= spi_mode(cpol, cpha);
                  spi_cs   <= cs_dec;
                  edge_cnt <= '0;
                  rx_sh    <= '0;
                  if (cpha) begin
                     tx_sh <= tx_data;
                  end else begin
                     spi_mosi <= tx_data[data_w-1];
                     tx_sh    <= tx_data << 1;
                  end
               end
            end
            ST_SETUP: begin
               if (tick) state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (tick) begin
                  edge_cnt <= edge_cnt + EDGE_W'(1);
                  if (leading != lead_drive) begin
                     rx_sh <= {rx_sh[data_w-2:0], in_bit};
                  end else if (edge_cnt != LAST_EDGE) begin
                     spi_mosi <= tx_sh[data_w-1];
                     tx_sh    <= tx_sh << 1;
                  end
                  if (edge_cnt == LAST_EDGE) begin
                     spi_sck <= idle_lvl;
                     state   <= ST_HOLD;
                  end else begin
                     spi_sck <= ~spi_sck;
                  end
               end
            end
            ST_HOLD: begin
               // The done cycle is spent still in HOLD so a start coincident with done is dropped.
               if (done) begin
                  state <= ST_IDLE;
               end else if (tick) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  rx_data <= rx_sh;
                  spi_cs  <= {cs_w{CS_IDLE}};
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_shifter.sv
// Self-checking bench for spi_shifter: directed mode/boundary cases plus random transfers
// against a bit-level slave model; a 6-line twin instance covers the out-of-range chip select.
module tb_spi_shifter;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] tx_data;
   logic [15:0] div;
   logic       cpol;
   logic       cpha;
   logic [2:0] cs_sel;
   logic       spi_miso;
`ifdef SPI_SHIFTER_LOOPBACK_EN
   logic       loopback;
`endif

   logic       busy, done, spi_mosi, spi_sck;
   logic [7:0] rx_data, spi_cs;
   logic       busy6, done6, mosi6, sck6;
   logic [7:0] rx6;
   logic [5:0] cs6;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   spi_shifter #(.data_w(8), .cs_w(8), .div_w(16)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .tx_data  (tx_data),
      .div      (div),
      .cpol     (cpol),
      .cpha     (cpha),
      .cs_sel   (cs_sel),
`ifdef SPI_SHIFTER_LOOPBACK_EN
      .loopback (loopback),
`endif
      .busy     (busy),
      .done     (done),
      .rx_data  (rx_data),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso),
      .spi_sck  (spi_sck),
      .spi_cs   (spi_cs)
   );

   spi_shifter #(.data_w(8), .cs_w(6), .div_w(16)) u_dut6 (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .tx_data  (tx_data),
      .div      (div),
      .cpol     (cpol),
      .cpha     (cpha),
      .cs_sel   (cs_sel),
`ifdef SPI_SHIFTER_LOOPBACK_EN
      .loopback (loopback),
`endif
      .busy     (busy6),
      .done     (done6),
      .rx_data  (rx6),
      .spi_mosi (mosi6),
      .spi_miso (spi_miso),
      .spi_sck  (sck6),
      .spi_cs   (cs6)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // One complete transfer with a slave model on MISO and a bit collector on MOSI.
   task automatic run_xfer(input string tag, input logic [7:0] tx, input logic [7:0] mw,
                           input logic [15:0] dv, input logic pol, input logic pha,
                           input logic [2:0] sel, input logic lb, input bit poke);
      int exp_busy, busy_cnt, done_cnt, done6_cnt, done_at, edges, midx;
      logic [7:0] mosi_bits, exp_cs8, exp_rx;
      logic [5:0] exp_cs6;
      logic prev_sck, prev_mosi, lead;
      bit cs_ok, cs6_ok, chg_ok, twin_ok, done_ok;

      exp_busy  = (2*8 + 2) * (int'(dv) + 1);
      exp_cs8   = ~(8'h01 << sel);
      exp_cs6   = (sel >= 3'd6) ? 6'h3F : ~(6'h01 << sel);
      exp_rx    = lb ? tx : mw;
      busy_cnt  = 0; done_cnt = 0; done6_cnt = 0; done_at = -1; edges = 0; midx = 0;
      mosi_bits = 8'h00;
      cs_ok = 1; cs6_ok = 1; chg_ok = 1; twin_ok = 1; done_ok = 1;

      cpol = pol;
      @(negedge clk);
      @(negedge clk);
      check({tag, "_sck_idle"}, 32'(spi_sck), 32'(pol));

      tx_data  = tx;
      div      = dv;
      cpha     = pha;
      cs_sel   = sel;
`ifdef SPI_SHIFTER_LOOPBACK_EN
      loopback = lb;
`endif
      spi_miso = mw[7];
      start    = 1'b1;
      prev_sck  = spi_sck;
      prev_mosi = spi_mosi;

      for (int n = 1; n <= exp_busy + 6; n++) begin
         @(negedge clk);
         if (n == 1) begin
            start   = 1'b0;
            tx_data = 8'($urandom);
            div     = 16'($urandom);
            cpha    = ~pha;
            cs_sel  = sel + 3'd1;
`ifdef SPI_SHIFTER_LOOPBACK_EN
            loopback = ~lb;
`endif
         end
         if (poke && n == 5) start = 1'b1;
         if (poke && n == 6) start = 1'b0;
         if (busy) begin
            busy_cnt++;
            if (spi_cs !== exp_cs8) cs_ok = 0;
            if (cs6 !== exp_cs6) cs6_ok = 0;
         end
         if (spi_sck !== prev_sck) begin
            edges++;
            lead = (edges % 2) == 1;
            if (lead != pha) begin
               mosi_bits = {mosi_bits[6:0], spi_mosi};
               midx++;
               spi_miso = (midx < 8) ? mw[7-midx] : 1'b0;
            end
         end
         if (spi_mosi !== prev_mosi) begin
            if (!((n == 1 && !pha) ||
                  (spi_sck !== prev_sck && (pha ? (spi_sck !== pol) : (spi_sck === pol)))))
               chg_ok = 0;
         end
         if (busy6 !== busy || sck6 !== spi_sck || mosi6 !== spi_mosi) twin_ok = 0;
         if (done6) done6_cnt++;
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = n;
            if (busy !== 1'b0 || spi_cs !== 8'hFF || cs6 !== 6'h3F) done_ok = 0;
            if (poke) start = 1'b1;
         end else if (poke && done_at > 0 && n == done_at + 1) begin
            start = 1'b0;
         end
         prev_sck  = spi_sck;
         prev_mosi = spi_mosi;
      end
      start    = 1'b0;
      spi_miso = 1'b0;

      check({tag, "_busy_len"}, 32'(busy_cnt), 32'(exp_busy));
      check({tag, "_done_at"},  32'(done_at),  32'(exp_busy + 1));
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({tag, "_done6_cnt"}, 32'(done6_cnt), 32'd1);
      check({tag, "_done_cycle"}, 32'(done_ok), 32'd1);
      check({tag, "_edges"},    32'(edges),    32'd16);
      check({tag, "_mosi"},     32'(mosi_bits), 32'(tx));
      check({tag, "_rx"},       32'(rx_data),  32'(exp_rx));
      check({tag, "_rx6"},      32'(rx6),      32'(exp_rx));
      check({tag, "_cs"},       32'(cs_ok),    32'd1);
      check({tag, "_cs6"},      32'(cs6_ok),   32'd1);
      check({tag, "_mosi_edge"}, 32'(chg_ok),  32'd1);
      check({tag, "_twin"},     32'(twin_ok),  32'd1);
      check({tag, "_sck_end"},  32'(spi_sck),  32'(pol));
   endtask

   initial begin
      int dcnt, bcnt;
      rst = 1'b1; start = 1'b0; tx_data = 8'h00; div = 16'h0000;
      cpol = 1'b1; cpha = 1'b0; cs_sel = 3'd0; spi_miso = 1'b0;
`ifdef SPI_SHIFTER_LOOPBACK_EN
      loopback = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rx",   32'(rx_data), 32'd0);
      check("rst_mosi", 32'(spi_mosi), 32'd0);
      check("rst_sck",  32'(spi_sck), 32'd0);
      check("rst_cs",   32'(spi_cs), 32'hFF);
      check("rst_cs6",  32'(cs6), 32'h3F);
      rst = 1'b0;

      // Reset in the middle of SHIFT (mode 3 so an idle SCK would read 1, not 0).
      cpol = 1'b1; cpha = 1'b1; div = 16'd1; tx_data = 8'h96; cs_sel = 3'd4;
      @(negedge clk); @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      check("rstmid_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rstmid_cs",   32'(spi_cs), 32'hFF);
      check("rstmid_sck",  32'(spi_sck), 32'd0);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_done", 32'(done), 32'd0);
      rst = 1'b0;
      dcnt = 0; bcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) dcnt++;
         if (busy) bcnt++;
      end
      check("rstmid_no_done", 32'(dcnt), 32'd0);
      check("rstmid_no_busy", 32'(bcnt), 32'd0);
      check("rstmid_rx",      32'(rx_data), 32'd0);

      run_xfer("m0_a5",   8'hA5, 8'h3C, 16'd0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0);
      run_xfer("m3_81",   8'h81, 8'hFF, 16'd3, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
      run_xfer("poke",    8'h5A, 8'hC6, 16'd0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b1);
      run_xfer("cs_oor",  8'h55, 8'h0F, 16'd1, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
      run_xfer("m2_e7",   8'hE7, 8'h18, 16'd2, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0);

      for (int k = 0; k < 6; k++) begin
         run_xfer($sformatf("rnd%0d", k), 8'($urandom), 8'($urandom),
                  16'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  3'($urandom), 1'b0, 1'b0);
      end

`ifdef SPI_SHIFTER_LOOPBACK_EN
      run_xfer("loopback", 8'hC3, 8'h00, 16'd1, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_shifter.md
Name: spi_shifter

Overview:
- SPI master shift engine. It serialises one data_w-bit word onto MOSI and captures MISO in parallel.
- Generates SCK with a programmable divider, in CPOL/CPHA modes 0–3.
- Drives an active-low one-hot chip select.
- Sits directly downstream of the SPI register/control block, which is reached from the AHB slave wrapper. That block issues start and transfer settings and consumes done/rx_data.

Parameters:
- data_w, 8, bits per transfer (≥2).
- cs_w, 8, number of chip-select lines.
- div_w, 16, width of the clock-divider setting.

Ports:
- clk  in  1  single system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  transfer request pulse; sampled only in IDLE.
- tx_data  in  data_w  word to transmit; latched at accepted start.
- div  in  div_w  SCK half-period = div+1 clk cycles; latched at start.
- cpol  in  1  SCK idle level.
- cpha  in  1  0: sample leading edge; 1: sample trailing edge. Latched at start.
- cs_sel  in  $clog2(cs_w)  chip select index; latched at start.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse at transfer end.
- rx_data  out  data_w  received word; updated only with done.
- spi_mosi  out  1  serial data out.
- spi_miso  in  1  serial data in.
- spi_sck  out  1  serial clock.
- spi_cs  out  cs_w  chip selects, active low.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, rx_data=0, spi_mosi=0, spi_sck=0, spi_cs=all 1s, FSM=IDLE, counters=0.
- Reset mid-transfer aborts immediately to the reset state. No done pulse is produced.

FSM states: IDLE, SETUP, SHIFT, HOLD.
- IDLE:
  - spi_sck is registered from the live cpol input.
  - start=1 latches tx_data/div/cpol/cpha/cs_sel and moves to SETUP.
  - busy rises the next cycle.
- SETUP:
  - spi_cs[cs_sel]=0. If cs_sel ≥ cs_w, no line is asserted but the transfer still runs.
  - If cpha=0, MSB is on spi_mosi from the first SETUP cycle.
  - Lasts div+1 cycles.
- SHIFT:
  - A half-period tick every div+1 cycles toggles SCK, for exactly 2*data_w edges.
  - Odd edges are leading, even edges are trailing.
  - cpha=0: sample MISO on leading edge; drive next bit on trailing edge, except after the last bit.
  - cpha=1: drive bit on leading edge; sample on trailing edge.
  - Bit order is MSB first. SCK returns to cpol after the final edge.
- HOLD:
  - CS stays asserted for div+1 cycles, then all CS lines deassert.
  - rx_data takes the shift register value; done=1 for one cycle; busy=0 in that same cycle; FSM returns to IDLE.
- Timing: busy lasts (2*data_w+2)*(div+1) cycles. Next start is accepted in the cycle after done.
- start while busy is ignored; it is not queued.
- start in the same cycle as done is ignored (FSM not yet IDLE).
- Input changes during a transfer have no effect on that transfer, because all settings are latched.
- div counter runs modulo div+1 with no wrap hazard; div=all 1s gives a 2^div_w-cycle half-period.

Optional Feature:
- Macro SPI_SHIFTER_LOOPBACK_EN.
- Defined:
  - Adds input port loopback (1 bit).
  - When loopback=1, the sampled bit is the internal MOSI register instead of spi_miso; pins still toggle.
  - loopback is latched at start.
- Undefined: no port; spi_miso is always sampled.

Decomposition:
- Package spi_pkg holds:
  - typedef enum of the FSM states;
  - localparams CS_IDLE='1 and SPI_MODE0..3 encodings ({cpol,cpha}).
- One sub-module, spi_clk_div:
  - counts div+1 cycles while enabled;
  - outputs a one-cycle tick;
  - resets count on !en.

Test Plan:
- Mode 0, div=0, tx=0xA5, MISO driven 0x3C:
  - 8 rising SCK edges on which MOSI reads 10100101;
  - busy high for 18 cycles;
  - done in cycle 19 after start;
  - rx_data=0x3C; cs_sel=2 → spi_cs=8'hFB during transfer, else 8'hFF.
- Mode 3, div=3, tx=0x81, MISO=0xFF:
  - SCK idles 1 and half-period is 4 cycles;
  - busy 72 cycles; rx_data=0xFF;
  - MOSI changes only on falling SCK.
- start pulsed 5 cycles into a busy transfer, and again in the done cycle → no second transfer; exactly one done pulse.
- rst asserted mid-SHIFT:
  - next cycle spi_cs=FF, sck=0, busy=0;
  - no done pulse; rx_data unchanged (0).
- cs_sel=cs_w (out of range), tx=0x55 → all CS stay high; SCK/MOSI run; done pulse occurs.
- With SPI_SHIFTER_LOOPBACK_EN, loopback=1, spi_miso held 0, tx=0xC3 → rx_data=0xC3.
